vga_fb_arbiter: RTL and testbench

//  Shares one single-port synchronous framebuffer RAM between VGA scanout and a pixel-writer client.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_pixel_fifo.sv | 65 ++++++
 rtl/vga_fb_arbiter.sv | 154 +++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA framebuffer arbiter slice.
package vga_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int FB_WORDS   = H_ACTIVE * V_ACTIVE;
    localparam int DATA_W     = 12;
    localparam int ADDR_W     = 19;
    localparam int FIFO_DEPTH = 16;

    typedef logic [DATA_W-1:0] pixel_t;
    typedef logic [ADDR_W-1:0] fb_addr_t;

    typedef enum logic [1:0] {
        WAIT_VS,
        FLUSH,
        RUN
    } arb_state_e;

endpackage

// File: rtl/vga_pixel_fifo.sv
// Scanout prefetch FIFO: first-word-fall-through, synchronous flush,
// simultaneous push and pop allowed (including push while full with pop).
module vga_pixel_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        data_i,
    output logic [DATA_W-1:0]        data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);
    localparam int PW = $clog2(DEPTH);

    pixel_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic [PW:0]   count_d;
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full | pop_ok);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage array carries no reset; only pointers and count are control.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    // Occupancy follows push/pop; equal push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok)      count_d = count_q + (PW+1)'(1);
        else if (pop_ok && !push_ok) count_d = count_q - (PW+1)'(1);
    end

    // Pointer and count registers, cleared by reset or flush.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port framebuffer RAM between VGA scanout (prefetch FIFO,
// absolute priority) and a pixel writer that takes every other slot.
// Optional macro VGA_FB_ARB_STATS_EN adds o_wr_stall_cnt (blocked-writer cycles).
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int FIFO_DEPTH = vga_pkg::FIFO_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_vs,
    input  logic              i_activeArea,
    output logic [DATA_W-1:0] o_pixel,
    output logic              o_underflow,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
`ifdef VGA_FB_ARB_STATS_EN
    ,
    output logic [15:0]       o_wr_stall_cnt
`endif
);
    localparam int       CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam fb_addr_t FRAME_END = ADDR_W'(H_ACTIVE * V_ACTIVE);

    arb_state_e       state_q;
    logic             vs_q;
    fb_addr_t         fetch_addr_q;
    fb_addr_t         fetch_addr_d;
    logic             inflight_q;
    pixel_t           pixel_q;
    logic             underflow_q;
    pixel_t           fifo_data;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             vs_fall;
    logic             vs_rise;
    logic             in_run;
    logic             enter_flush;
    logic             pop_req;
    logic             pop_eff;
    logic             fetch_issue;
    logic             wr_grant;
    logic [CNT_W:0]   credit_used;
    logic [CNT_W:0]   credit_limit;

    assign vs_fall     = vs_q & ~i_vs;
    assign vs_rise     = ~vs_q & i_vs;
    assign in_run      = (state_q == RUN);
    assign enter_flush = vs_fall & (state_q != FLUSH);
    assign pop_req     = in_run & i_activeArea;
    assign pop_eff     = pop_req & ~fifo_empty;

    // A slot is reserved for every read in flight, so the FIFO can never
    // overflow; a same-cycle pop frees one entry, which keeps one fetch per
    // active pixel and leaves no slot to the writer during a burst.
    assign credit_used  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign credit_limit = (CNT_W+1)'(FIFO_DEPTH) + {{CNT_W{1'b0}}, pop_eff};
    assign fetch_issue  = in_run & (credit_used < credit_limit) & (fetch_addr_q < FRAME_END);

    assign wr_grant    = i_wr_valid & ~fetch_issue;
    assign o_wr_ready  = wr_grant;
    assign o_mem_en    = fetch_issue | wr_grant;
    assign o_mem_we    = wr_grant;
    assign o_mem_addr  = fetch_issue ? fetch_addr_q : (wr_grant ? i_wr_addr : '0);
    assign o_mem_wdata = wr_grant ? i_wr_data : '0;
    assign o_pixel     = pixel_q;
    assign o_underflow = underflow_q;

    // Read data arriving outside RUN belongs to a discarded frame and is dropped.
    vga_pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .flush_i (state_q == FLUSH),
        .push_i  (inflight_q & in_run),
        .pop_i   (pop_req),
        .data_i  (i_mem_rdata),
        .data_o  (fifo_data),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    // Frame FSM with registered scanout pixel and sticky underflow flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= WAIT_VS;
            vs_q        <= 1'b1;
            pixel_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            vs_q <= i_vs;
            case (state_q)
                WAIT_VS: if (vs_fall) state_q <= FLUSH;
                FLUSH:   if (vs_rise) state_q <= RUN;
                RUN:     if (vs_fall) state_q <= FLUSH;
                default: state_q <= WAIT_VS;
            endcase
            pixel_q <= pop_eff ? fifo_data : '0;
            if (enter_flush)                underflow_q <= 1'b0;
            else if (pop_req && fifo_empty) underflow_q <= 1'b1;
        end
    end

    // Fetch address restarts in FLUSH and stops advancing at end of frame.
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        if (state_q == FLUSH)  fetch_addr_d = '0;
        else if (fetch_issue)  fetch_addr_d = fetch_addr_q + ADDR_W'(1);
    end

    // Fetch address and one-deep in-flight read marker.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fetch_addr_q <= '0;
            inflight_q   <= 1'b0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            inflight_q   <= fetch_issue;
        end
    end

`ifdef VGA_FB_ARB_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    // Saturating count of cycles the writer was held off by scanout.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (enter_flush)
            stall_cnt_d = '0;
        else if (i_wr_valid && fetch_issue && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // Stall counter register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) stall_cnt_q <= '0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    assign o_wr_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter using a reduced 640x4 frame.
module tb_vga_fb_arbiter;
    import vga_pkg::*;

    localparam int H  = 640;
    localparam int V  = 4;
    localparam int FB = H * V;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              vs = 1'b1;
    logic              act = 1'b0;
    logic              wr_valid = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [DATA_W-1:0] pixel;
    logic              underflow;
    logic              wr_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
`ifdef VGA_FB_ARB_STATS_EN
    logic [15:0]       stall_cnt;
`endif

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .FIFO_DEPTH (16)
    ) dut (
`ifdef VGA_FB_ARB_STATS_EN
        .o_wr_stall_cnt (stall_cnt),
`endif
        .i_clk        (clk),
        .i_reset      (rst),
        .i_vs         (vs),
        .i_activeArea (act),
        .o_pixel      (pixel),
        .o_underflow  (underflow),
        .i_wr_valid   (wr_valid),
        .o_wr_ready   (wr_ready),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .o_mem_en     (mem_en),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata)
    );

    // RAM model: unwritten words read back their own address.
    bit          wr_seen [4096];
    logic [11:0] wmem    [4096];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                wmem[mem_addr[11:0]]    <= mem_wdata;
                wr_seen[mem_addr[11:0]] <= 1'b1;
            end else begin
                mem_rdata <= wr_seen[mem_addr[11:0]] ? wmem[mem_addr[11:0]] : mem_addr[11:0];
            end
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct {
        int                due;
        logic [DATA_W-1:0] val;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   pcnt = 0;

    always @(posedge clk) pcnt <= pcnt + 1;

    // Monitor: fetch sequence is 0,1,2,... from each frame start; pixel scoreboard.
    int   fetch_cnt  = 0;
    int   last_fetch = -1;
    logic vs_m       = 1'b1;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            fetch_cnt  = 0;
            last_fetch = -1;
        end else begin
            if (mem_en && !mem_we) begin
                check("fetch_addr", 32'(mem_addr), fetch_cnt);
                last_fetch = int'(mem_addr);
                fetch_cnt++;
            end
            if (vs_m && !vs) begin
                fetch_cnt  = 0;
                last_fetch = -1;
            end
        end
        vs_m = vs;
        if (sbq.size() > 0 && sbq[0].due <= pcnt) begin
            e = sbq.pop_front();
            check("pixel", 32'(pixel), 32'(e.val));
        end
    end

    task automatic px(input logic a, input logic [DATA_W-1:0] ev);
        @(negedge clk);
        act = a;
        sbq.push_back('{due: pcnt + 1, val: ev});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            act = 1'b0;
        end
    endtask

    task automatic vs_pulse();
        @(negedge clk);
        vs = 1'b0;
        repeat (3) @(negedge clk);
        vs = 1'b1;
    endtask

    function automatic logic [DATA_W-1:0] ramp(input int p);
        return (p == 5) ? 12'hABC : DATA_W'(p);
    endfunction

    int nf;
    int p;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #2;
        check("rst_pixel", 32'(pixel), 0);
        check("rst_underflow", 32'(underflow), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_wr_ready", 32'(wr_ready), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #2 check("waitvs_nofetch", 32'(mem_en), 0);
        end

        // 1: fill after vs pulse, then writer owns every slot
        vs_pulse();
        nf = 0;
        repeat (25) begin
            @(negedge clk);
            #2 if (mem_en && !mem_we) nf++;
        end
        check("t1_fetch_count", nf, 16);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = ADDR_W'(3000);
        wr_data  = 12'h123;
        repeat (8) begin
            #2;
            check("t1_wr_ready", 32'(wr_ready), 1);
            check("t1_mem_we", 32'(mem_we), 1);
            @(negedge clk);
        end

        // 2: 640-pixel burst, writer blocked throughout
        for (int i = 0; i < H; i++) begin
            px(1'b1, DATA_W'(i));
            #2 check("t2_wr_blocked", 32'(wr_ready), 0);
        end
        px(1'b0, '0);
        wr_valid = 1'b0;
        idle(3);
        #2 check("t2_underflow", 32'(underflow), 0);
`ifdef VGA_FB_ARB_STATS_EN
        check("t2_stall_cnt", 32'(stall_cnt), H);
`endif

        // 3: active immediately after vs rise, FIFO starved for two pops
        vs_pulse();
        px(1'b1, '0);
        px(1'b1, '0);
        for (int j = 2; j < 12; j++) px(1'b1, DATA_W'(j - 2));
        px(1'b0, '0);
        repeat (5) begin
            @(negedge clk);
            #2 check("t3_underflow_sticky", 32'(underflow), 1);
        end
        @(negedge clk);
        vs = 1'b0;
        @(negedge clk);
        #2 check("t3_underflow_clear", 32'(underflow), 0);

        // 5: write addr 5 during blanking (vs still low)
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = ADDR_W'(5);
        wr_data  = 12'hABC;
        #2;
        check("t5_wr_ready", 32'(wr_ready), 1);
        check("t5_mem_we", 32'(mem_we), 1);
        check("t5_mem_addr", 32'(mem_addr), 5);
        check("t5_mem_wdata", 32'(mem_wdata), 32'h0ABC);
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        vs = 1'b1;
        idle(25);

        // 4: full frame with line gaps; pixel 5 shows the written value
        for (int ln = 0; ln < V; ln++) begin
            for (int x = 0; x < H; x++) begin
                p = ln * H + x;
                px(1'b1, ramp(p));
            end
            for (int g = 0; g < 20; g++) px(1'b0, '0);
        end
        idle(30);
        #2;
        check("t4_last_fetch", last_fetch, FB - 1);
        check("t4_fetch_count", fetch_cnt, FB);
        check("t4_underflow", 32'(underflow), 0);
        repeat (5) begin
            @(negedge clk);
            #2 check("t4_fetch_stopped", 32'(mem_en), 0);
        end
        vs_pulse();
        @(negedge clk);
        #2;
        check("t4_restart_en", 32'(mem_en), 1);
        check("t4_restart_addr", 32'(mem_addr), 0);

        // 6: async reset mid-line with a read in flight
        idle(20);
        px(1'b1, ramp(0));
        px(1'b1, ramp(1));
        px(1'b1, ramp(2));
        @(negedge clk);
        act = 1'b1;
        #2 check("t6_read_issued", 32'(mem_en & ~mem_we), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        act = 1'b0;
        #1;
        check("t6_pixel", 32'(pixel), 0);
        check("t6_underflow", 32'(underflow), 0);
        check("t6_mem_en", 32'(mem_en), 0);
        check("t6_wr_ready", 32'(wr_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            px(1'b1, '0);
            #2 check("t6_no_scanout", 32'(mem_en), 0);
        end
        px(1'b0, '0);
        vs_pulse();
        idle(25);
        for (int k = 0; k < 8; k++) px(1'b1, ramp(k));
        px(1'b0, '0);
        idle(4);
        #2 check("sb_drained", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
